// File: rtl/merger_pkg.sv
// Shared widths and word type for the 3b/13b field merger.
package merger_pkg;
    localparam int A_W = 3;
    localparam int B_W = 13;
    localparam int R_W = A_W + B_W;

    typedef logic [R_W-1:0] word_t;
endpackage

// File: rtl/merger_reg.sv
// Enable register with synchronous active-high reset and a "loaded since reset" flag.
module merger_reg #(
    parameter int W = merger_pkg::R_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q,
    output logic         o_vld
);
    logic [W-1:0] r_q;
    logic         r_vld;

    // Reset wins over a same-edge load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q   <= '0;
            r_vld <= 1'b0;
        end else if (i_en) begin
            r_q   <= i_d;
            r_vld <= 1'b1;
        end
    end

    assign o_q   = r_q;
    assign o_vld = r_vld;
endmodule

// File: rtl/merger_3b_13b.sv
// Packs a 3-bit tag/opcode over a 13-bit immediate into a 16-bit word, combinational and registered.
module merger_3b_13b
    import merger_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic [A_W-1:0] a,
    input  logic [B_W-1:0] b,
    input  logic           en,
    output word_t          r,
    output word_t          r_q,
    output logic           vld_q
);
    word_t w_merged;

    // Pure bit placement: no clock, reset or enable in this path.
    assign w_merged = {a, b};
    assign r        = w_merged;

    merger_reg #(.W(R_W)) u_reg (
        .clk   (clk),
        .rst   (rst),
        .i_en  (en),
        .i_d   (w_merged),
        .o_q   (r_q),
        .o_vld (vld_q)
    );
endmodule

// File: tb/tb_merger_3b_13b.sv
// Directed bench for merger_3b_13b: combinational merge, register load/hold and reset priority.
module tb_merger_3b_13b;
    import merger_pkg::*;

    logic           clk = 1'b0;
    logic           clk_run = 1'b1;
    logic           rst = 1'b1;
    logic [A_W-1:0] a = '0;
    logic [B_W-1:0] b = '0;
    logic           en = 1'b0;
    word_t          r, r_q;
    logic           vld_q;

    int n_cmp = 0;
    int n_bad = 0;

    merger_3b_13b dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .b     (b),
        .en    (en),
        .r     (r),
        .r_q   (r_q),
        .vld_q (vld_q)
    );

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; en = 1'b0;
        step();
        step();
        n_cmp++;
        if (r_q !== 16'h0000) begin
            n_bad++; $display("FAIL reset_r_q: got %h expected %h", r_q, 16'h0000);
        end
        n_cmp++;
        if (vld_q !== 1'b0) begin
            n_bad++; $display("FAIL reset_vld_q: got %b expected %b", vld_q, 1'b0);
        end
    endtask

    task automatic test_comb_noclk();
        @(negedge clk);
        clk_run = 1'b0;
        a = 3'b111; b = 13'b0000000000111;
        #10;
        n_cmp++;
        if (r !== 16'hE007) begin
            n_bad++; $display("FAIL comb_noclk: got %h expected %h", r, 16'hE007);
        end
        n_cmp++;
        if (r_q !== 16'h0000) begin
            n_bad++; $display("FAIL noclk_r_q_stable: got %h expected %h", r_q, 16'h0000);
        end
        clk_run = 1'b1;
    endtask

    task automatic test_comb_patterns();
        logic [A_W-1:0] va [6] = '{3'b110, 3'b000, 3'b001, 3'b000, 3'b100, 3'b010};
        logic [B_W-1:0] vb [6] = '{13'b0101000100100, 13'h0000, 13'h0000, 13'h1000, 13'h0000, 13'h1555};
        word_t          ve [6] = '{16'hCA24, 16'h0000, 16'h2000, 16'h1000, 16'h8000, 16'h5555};
        for (int i = 0; i < 6; i++) begin
            a = va[i]; b = vb[i];
            #10;
            n_cmp++;
            if (r !== ve[i]) begin
                n_bad++; $display("FAIL comb_vec%0d: got %h expected %h", i, r, ve[i]);
            end
        end
    endtask

    task automatic test_load_hold();
        @(negedge clk);
        rst = 1'b0; en = 1'b1; a = 3'd7; b = 13'd7;
        #1;
        n_cmp++;
        if (vld_q !== 1'b0 || r_q !== 16'h0000) begin
            n_bad++; $display("FAIL load_latency: got r_q=%h vld=%b expected 0000/0", r_q, vld_q);
        end
        step();
        n_cmp++;
        if (r_q !== 16'hE007) begin
            n_bad++; $display("FAIL load_r_q: got %h expected %h", r_q, 16'hE007);
        end
        n_cmp++;
        if (vld_q !== 1'b1) begin
            n_bad++; $display("FAIL load_vld: got %b expected %b", vld_q, 1'b1);
        end
        @(negedge clk);
        en = 1'b0; a = 3'd2; b = 13'd5;
        step();
        step();
        n_cmp++;
        if (r_q !== 16'hE007 || vld_q !== 1'b1) begin
            n_bad++; $display("FAIL hold: got r_q=%h vld=%b expected E007/1", r_q, vld_q);
        end
        n_cmp++;
        if (r !== 16'h4005) begin
            n_bad++; $display("FAIL hold_comb: got %h expected %h", r, 16'h4005);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        en = 1'b1; a = 3'd1; b = 13'h1FFF;
        step();
        n_cmp++;
        if (r_q !== 16'h3FFF) begin
            n_bad++; $display("FAIL b2b_0: got %h expected %h", r_q, 16'h3FFF);
        end
        @(negedge clk);
        a = 3'd5; b = 13'h0AAA;
        step();
        n_cmp++;
        if (r_q !== 16'hAAAA) begin
            n_bad++; $display("FAIL b2b_1: got %h expected %h", r_q, 16'hAAAA);
        end
    endtask

    task automatic test_reset_priority();
        @(negedge clk);
        rst = 1'b1; en = 1'b1; a = 3'd6; b = 13'h0A24;
        #1;
        n_cmp++;
        if (r !== 16'hCA24) begin
            n_bad++; $display("FAIL rstpri_comb_pre: got %h expected %h", r, 16'hCA24);
        end
        step();
        n_cmp++;
        if (r_q !== 16'h0000 || vld_q !== 1'b0) begin
            n_bad++; $display("FAIL rstpri_reg: got r_q=%h vld=%b expected 0000/0", r_q, vld_q);
        end
        n_cmp++;
        if (r !== 16'hCA24) begin
            n_bad++; $display("FAIL rstpri_comb_post: got %h expected %h", r, 16'hCA24);
        end
        @(negedge clk);
        rst = 1'b0;
        step();
        n_cmp++;
        if (r_q !== 16'hCA24 || vld_q !== 1'b1) begin
            n_bad++; $display("FAIL post_rst_load: got r_q=%h vld=%b expected CA24/1", r_q, vld_q);
        end
    endtask

    initial begin
        test_reset();
        test_comb_noclk();
        test_comb_patterns();
        test_load_hold();
        test_back_to_back();
        test_reset_priority();
        if (n_bad == 0) $display("ALL TESTS PASSED");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
